// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus controller.
// The region decode lives here so the controller and any future peripherals agree on the memory map.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_DMA,
    REG_PRG,
    REG_OPEN
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] PPU_END      = 16'h4000;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [2:0]  OAM_DATA_REG = 3'd4;
  localparam logic [15:0] PRG_BASE     = 16'h8000;

  function automatic region_t decode_region(input logic [15:0] addr);
    region_t r;
    if (addr < PPU_BASE)            r = REG_RAM;
    else if (addr < PPU_END)        r = REG_PPU;
    else if (addr == OAM_DMA_ADDR)  r = REG_DMA;
    else if (addr >= PRG_BASE)      r = REG_PRG;
    else                            r = REG_OPEN;
    return r;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA sequencer: stalls the CPU, aligns to the parity bit, then alternates
// one source read and one OAM data write per byte.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter int DMA_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  page,
  output logic        rdy,
  output logic        rd_phase,
  output logic        wr_phase,
  output logic [15:0] src_addr
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic       parity_q;
  logic       extra_q;

  // extra_q remembers the parity seen on the trigger write and buys one more ALIGN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
      extra_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (start && state_q == IDLE) begin
        page_q  <= page;
        idx_q   <= 8'h00;
        extra_q <= parity_q;
      end else if (state_q == ALIGN) begin
        extra_q <= 1'b0;
      end
      if (state_q == DMA_WR)
        idx_q <= (idx_q == LAST_IDX) ? 8'h00 : idx_q + 8'h01;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdy      = 1'b0;
    rd_phase = 1'b0;
    wr_phase = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (start) state_d = ALIGN;
      end
      ALIGN: begin
        if (!extra_q) state_d = DMA_RD;
      end
      DMA_RD: begin
        rd_phase = 1'b1;
        state_d  = DMA_WR;
      end
      DMA_WR: begin
        wr_phase = 1'b1;
        state_d  = (idx_q == LAST_IDX) ? IDLE : DMA_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign src_addr = {page_q, idx_q};

endmodule

// File: rtl/nes_cpu_bus.sv
// CPU-side bus controller: address decode and mirroring, registered read return,
// open-bus latch, and the OAM DMA engine that borrows the bus while cpu_rdy is low.
module nes_cpu_bus
  import nes_bus_pkg::*;
#(
  parameter int RAM_ADDR_W  = 11,
  parameter int PRG_ADDR_W  = 15,
  parameter bit OPEN_BUS_EN = 1'b1,
  parameter int DMA_LEN     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_dout,
  input  logic                  cpu_we,
  output logic [7:0]            cpu_din,
  output logic                  cpu_rdy,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  input  logic [7:0]            ram_dout,
  output logic                  prg_ena,
  output logic [PRG_ADDR_W-1:0] prg_addr,
  input  logic [7:0]            prg_data,
  output logic                  ppu_cs,
  output logic [2:0]            ppu_reg,
  output logic                  ppu_we,
  output logic [7:0]            ppu_din,
  input  logic [7:0]            ppu_dout
);

  logic        dma_rdy;
  logic        dma_rd;
  logic        dma_wr;
  logic        dma_start;
  logic [15:0] dma_src;
  logic [15:0] eff_addr;
  logic        cpu_wr;
  logic        bus_read;
  logic        rd_q;
  logic [7:0]  open_bus_q;
  region_t     region;
  region_t     sel_q;

  oam_dma #(.DMA_LEN(DMA_LEN)) u_dma (
    .clk      (clk),
    .rst      (rst),
    .start    (dma_start),
    .page     (cpu_dout),
    .rdy      (dma_rdy),
    .rd_phase (dma_rd),
    .wr_phase (dma_wr),
    .src_addr (dma_src)
  );

  // The DMA engine owns the address bus whenever the CPU is stalled.
  assign eff_addr  = dma_rdy ? cpu_addr : dma_src;
  assign region    = decode_region(eff_addr);
  assign cpu_wr    = dma_rdy && cpu_we && !rst;
  assign bus_read  = !rst && (dma_rdy || dma_rd);
  assign dma_start = cpu_wr && (region == REG_DMA);

  assign cpu_rdy  = dma_rdy;
  assign ram_addr = eff_addr[RAM_ADDR_W-1:0];
  assign ram_din  = cpu_dout;
  assign ram_we   = cpu_wr && (region == REG_RAM);
  assign prg_addr = eff_addr[PRG_ADDR_W-1:0];
  assign prg_ena  = bus_read && (region == REG_PRG);
  assign ppu_cs   = (bus_read && (region == REG_PPU)) || (dma_wr && !rst);
  assign ppu_reg  = dma_wr ? OAM_DATA_REG : eff_addr[2:0];
  assign ppu_we   = (cpu_wr && (region == REG_PPU)) || (dma_wr && !rst);
  assign ppu_din  = dma_wr ? cpu_din : cpu_dout;

  always_comb begin
    cpu_din = OPEN_BUS_EN ? open_bus_q : 8'hFF;
    case (sel_q)
      REG_RAM: cpu_din = ram_dout;
      REG_PPU: cpu_din = ppu_dout;
      REG_PRG: cpu_din = prg_data;
      default: ;
    endcase
  end

  // A CPU write in the same cycle a mapped read returns is the later bus value, so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= REG_OPEN;
      rd_q       <= 1'b0;
      open_bus_q <= 8'h00;
    end else begin
      sel_q <= region;
      rd_q  <= dma_rdy && !cpu_we;
      if (cpu_wr)
        open_bus_q <= cpu_dout;
      else if (rd_q && sel_q != REG_OPEN && sel_q != REG_DMA)
        open_bus_q <= cpu_din;
    end
  end

endmodule
